bcd_seg_counter: RTL
====================

BCD_SEG_COUNTER -- requirements
Module: bcd_seg_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, giving the number of BCD digits (1..8).
REQ-002 The block SHALL have parameter MODULUS, default 100, giving the count range 0..MODULUS-1 (2..10**DIGITS).
REQ-003 The block SHALL have parameter PRESCALE, default 1, giving the number of enabled CLK cycles per count step (>=1).
REQ-004 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 EN  input  1  count enable; gates both the prescaler and the counter.
REQ-007 UP  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 LOAD  input  1  synchronous load strobe.
REQ-009 LOAD_VAL  input  DIGITS*4  BCD value to load; digit 0 in bits [3:0].
REQ-010 COUNT  output  DIGITS*4  registered BCD count; digit 0 in bits [3:0].
REQ-011 SEG  output  DIGITS*7  registered seven-segment patterns, active-high, per digit {g,f,e,d,c,b,a}; digit 0 in bits [6:0].
REQ-012 WRAP  output  1  one-cycle pulse on the edge where the count wraps in either direction.

Function
REQ-013 Priority SHALL be RST > LOAD > counting; LOAD acts regardless of EN and clears the prescaler.
REQ-014 On LOAD, COUNT SHALL take LOAD_VAL on the next edge, unless any digit is >9 or the value is >=MODULUS, in which case COUNT SHALL become 0.
REQ-015 With EN=1, the prescaler SHALL count 0..PRESCALE-1; a tick occurs on the cycle it equals PRESCALE-1, after which it returns to 0.
REQ-016 With EN=0, the prescaler and COUNT SHALL hold; no tick and no WRAP are produced.
REQ-017 On a tick with UP=1, COUNT SHALL increment in BCD with decimal carry between digits; MODULUS-1 SHALL wrap to 0.
REQ-018 On a tick with UP=0, COUNT SHALL decrement in BCD with decimal borrow; 0 SHALL wrap to MODULUS-1.
REQ-019 WRAP SHALL be 1 for exactly the one cycle following the edge that performs a wrap; it SHALL be 0 on load edges.
REQ-020 COUNT, SEG and WRAP SHALL update on the same edge (one-cycle latency from tick or LOAD to outputs); SEG always encodes the current COUNT.
REQ-021 Segment encodings SHALL be 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-022 A change of UP between ticks SHALL take effect on the next tick without disturbing the prescaler.

Reset
REQ-023 While RST=1, COUNT SHALL be 0, the prescaler 0, WRAP 0, and SEG SHALL show "0" on every digit (subject to REQ-026), immediately and without a CLK edge.
REQ-024 Deasserting RST SHALL start counting from the first enabled edge after release; a mid-operation reset SHALL discard the count and the prescaler phase.

Configuration
REQ-025 Macro BCD_SEG_COUNTER_LZB_EN SHALL enable leading-zero blanking.
REQ-026 With BCD_SEG_COUNTER_LZB_EN defined, each leading zero digit above digit 0 SHALL drive SEG 0000000, and digit 0 SHALL always be displayed; without it, all digits SHALL be displayed, zero digits included. COUNT is unaffected in both cases.

Structure
REQ-027 Package bcd_seg_counter_pkg SHALL hold the seg_t (7-bit) and bcd_t (4-bit) typedefs, the ten segment constants, and SEG_BLANK.
REQ-028 A sub-module bcd_to_seg (bcd_t in, seg_t out, combinational, out-of-range digit -> SEG_BLANK) SHALL be instantiated once per digit.

Verification
REQ-029 RST pulse with CLK stopped -> COUNT=0x00, SEG=0111111_0111111 (or 0000000_0111111 with LZB), WRAP=0, all asynchronously.
REQ-030 DIGITS=2, MODULUS=100, PRESCALE=1, UP=1, EN=1 for 100 cycles from 0 -> counts 00..99 then 00, with WRAP high only on the cycle after 99->00.
REQ-031 UP=0 from 00 -> next value 99 with WRAP pulse; MODULUS=60 -> 00 decrements to 59, and 59 increments to 00.
REQ-032 LOAD=1, LOAD_VAL=0x57 with EN=1 -> COUNT=0x57 next edge with no increment; LOAD_VAL=0x3A or 0x75 (MODULUS=60) -> COUNT=0x00.
REQ-033 PRESCALE=4, EN toggling 1,1,0,1,1 -> one increment after the fourth enabled cycle only; COUNT holds while EN=0.
REQ-034 RST asserted mid-count at 0x42 with prescaler at 2 -> 0x00 immediately; after release, the first increment occurs PRESCALE enabled cycles later.

Source files
------------

// File: rtl/bcd_seg_counter_pkg.sv
// Shared types, seven-segment constants and a BCD conversion helper for the
// bcd_seg_counter block.
package bcd_seg_counter_pkg;

   typedef logic [3:0] bcd_t;
   typedef logic [6:0] seg_t;

   // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
   localparam seg_t SEG_0     = 7'b0111111;
   localparam seg_t SEG_1     = 7'b0000110;
   localparam seg_t SEG_2     = 7'b1011011;
   localparam seg_t SEG_3     = 7'b1001111;
   localparam seg_t SEG_4     = 7'b1100110;
   localparam seg_t SEG_5     = 7'b1101101;
   localparam seg_t SEG_6     = 7'b1111101;
   localparam seg_t SEG_7     = 7'b0000111;
   localparam seg_t SEG_8     = 7'b1111111;
   localparam seg_t SEG_9     = 7'b1101111;
   localparam seg_t SEG_BLANK = 7'b0000000;

   // Wide enough for 10**8, the largest modulus an 8-digit counter can have.
   localparam int BCD_W = 40;

   function automatic logic [BCD_W-1:0] to_bcd(input int value);
      int                 v;
      logic [BCD_W-1:0]   r;
      v = value;
      r = '0;
      for (int i = 0; i < BCD_W / 4; i++) begin
         r[i*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to seven-segment decoder; non-decimal codes go dark.
module bcd_to_seg
   import bcd_seg_counter_pkg::*;
(
   input  bcd_t digit,
   output seg_t seg
);

   // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_seg_counter.sv
// Prescaled up/down BCD counter with loadable value and registered seven-segment
// outputs. Define BCD_SEG_COUNTER_LZB_EN to blank leading zero digits.
module bcd_seg_counter
   import bcd_seg_counter_pkg::*;
#(
   parameter int DIGITS   = 2,
   parameter int MODULUS  = 100,
   parameter int PRESCALE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [DIGITS*4-1:0]   load_val,
   output logic [DIGITS*4-1:0]   count,
   output logic [DIGITS*7-1:0]   seg,
   output logic                  wrap
);

   localparam int                 PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]      PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [BCD_W-1:0]   MOD_BCD  = to_bcd(MODULUS);
   localparam logic [BCD_W-1:0]   MAX_BCD  = to_bcd(MODULUS - 1);
   localparam logic [DIGITS*4-1:0] MAX_CNT = MAX_BCD[DIGITS*4-1:0];

   function automatic logic [DIGITS*7-1:0] reset_seg();
      logic [DIGITS*7-1:0] r;
      for (int i = 0; i < DIGITS; i++) begin
`ifdef BCD_SEG_COUNTER_LZB_EN
         r[i*7 +: 7] = (i == 0) ? SEG_0 : SEG_BLANK;
`else
         r[i*7 +: 7] = SEG_0;
`endif
      end
      return r;
   endfunction

   localparam logic [DIGITS*7-1:0] SEG_RST = reset_seg();

   logic [PW-1:0]        presc, presc_d;
   logic [DIGITS*4-1:0]  count_d, count_inc, count_dec;
   logic                 wrap_d, tick, load_ok, carry, borrow;
   logic [DIGITS*7-1:0]  seg_d;
   seg_t                 seg_raw [DIGITS];
`ifdef BCD_SEG_COUNTER_LZB_EN
   logic                 lead;
`endif

   assign tick = en && (presc == PRE_LAST);

   // Decimal carry/borrow ripple: a digit rolls over only while all lower digits did.
   always_comb begin
      count_inc = count;
      count_dec = count;
      carry     = 1'b1;
      borrow    = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (count[i*4 +: 4] == 4'd9) count_inc[i*4 +: 4] = 4'd0;
            else begin
               count_inc[i*4 +: 4] = count[i*4 +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (count[i*4 +: 4] == 4'd0) count_dec[i*4 +: 4] = 4'd9;
            else begin
               count_dec[i*4 +: 4] = count[i*4 +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   // With every digit decimal, BCD ordering matches numeric ordering.
   always_comb begin
      load_ok = (BCD_W'(load_val) < MOD_BCD);
      for (int i = 0; i < DIGITS; i++)
         if (load_val[i*4 +: 4] > 4'd9) load_ok = 1'b0;
   end

   always_comb begin
      count_d = count;
      presc_d = presc;
      wrap_d  = 1'b0;
      if (load) begin
         count_d = load_ok ? load_val : '0;
         presc_d = '0;
      end else if (en) begin
         if (tick) begin
            presc_d = '0;
            if (up) begin
               if (count == MAX_CNT) begin
                  count_d = '0;
                  wrap_d  = 1'b1;
               end else count_d = count_inc;
            end else begin
               if (count == '0) begin
                  count_d = MAX_CNT;
                  wrap_d  = 1'b1;
               end else count_d = count_dec;
            end
         end else presc_d = presc + 1'b1;
      end
   end

   // Decode the next count so the segment register lands on the same edge as COUNT.
   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      bcd_to_seg u_dec (
         .digit (count_d[g*4 +: 4]),
         .seg   (seg_raw[g])
      );
   end

   always_comb begin
      seg_d = '0;
`ifdef BCD_SEG_COUNTER_LZB_EN
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (i > 0 && lead && count_d[i*4 +: 4] == 4'd0) seg_d[i*7 +: 7] = SEG_BLANK;
         else begin
            seg_d[i*7 +: 7] = seg_raw[i];
            lead = 1'b0;
         end
      end
`else
      for (int i = 0; i < DIGITS; i++) seg_d[i*7 +: 7] = seg_raw[i];
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
         count <= '0;
         seg   <= SEG_RST;
         wrap  <= 1'b0;
      end else begin
         presc <= presc_d;
         count <= count_d;
         seg   <= seg_d;
         wrap  <= wrap_d;
      end
   end

endmodule
